// File: rtl/i2c_target_regs_pkg.sv
// Shared constants for the I2C register-bank target: FSM encodings, R/W bit position, ACK levels.
package i2c_target_regs_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE   = 4'd0;
  localparam state_t ST_ADDR   = 4'd1;
  localparam state_t ST_ACK_A  = 4'd2;
  localparam state_t ST_PTR    = 4'd3;
  localparam state_t ST_ACK_P  = 4'd4;
  localparam state_t ST_WRITE  = 4'd5;
  localparam state_t ST_ACK_W  = 4'd6;
  localparam state_t ST_READ   = 4'd7;
  localparam state_t ST_MACK   = 4'd8;
  localparam state_t ST_IGNORE = 4'd9;

  localparam int   RW_BIT   = 0;
  localparam logic ACK_LVL  = 1'b0;
  localparam logic NACK_LVL = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus FILTER_LEN-sample glitch filter for one bus line, with edge pulses.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0]            sync_q, sync_d;
  logic [FILTER_LEN-1:0] hist_q, hist_d;
  logic                  filt_q, filt_d;
  logic                  prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[0], line_in};
    hist_d = FILTER_LEN'({hist_q, sync_q[1]});
    prev_d = filt_q;
    filt_d = filt_q;
    // Level changes only once the whole history window agrees.
    if (&hist_q)       filt_d = 1'b1;
    else if (~|hist_q) filt_d = 1'b0;
  end

  // Idle I2C lines are pulled high, so everything resets to 1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
      hist_q <= '1;
      filt_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      filt_q <= filt_d;
      prev_q <= prev_d;
    end
  end

  assign level = filt_q;
  assign rise  = filt_q & ~prev_q;
  assign fall  = ~filt_q & prev_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing an external register bank through a pointer with auto-increment.
module i2c_target_regs
  import i2c_target_regs_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDRESS = 7'h1A,
  parameter int         FILTER_LEN     = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       serial_clock_line,
  inout  wire        serial_data_line,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  logic scl_level, scl_rise, scl_fall;
  logic sda_level, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clock(clock), .reset(reset), .line_in(serial_clock_line),
    .level(scl_level), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clock(clock), .reset(reset), .line_in(serial_data_line),
    .level(sda_level), .rise(sda_rise), .fall(sda_fall)
  );

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       reg_we_q, reg_we_d;
  logic       reg_re_q, reg_re_d;
  logic       busy_q, busy_d;
  logic       sda_oe_q, sda_oe_d;

  logic       start_det, stop_det, last_bit;
  logic [7:0] byte_in;

  assign start_det = sda_fall & scl_level;
  assign stop_det  = sda_rise & scl_level;
  assign last_bit  = (bit_cnt_q == 3'd7);
  assign byte_in   = {shift_q[6:0], sda_level};

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    busy_d      = busy_q;
    sda_oe_d    = sda_oe_q;
    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WRITE: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              if (state_q == ST_ADDR) begin
                if (byte_in[7:1] == TARGET_ADDRESS) begin
                  state_d = ST_ACK_A;
                  busy_d  = 1'b1;
                end else begin
                  state_d = ST_IGNORE;
                end
              end else if (state_q == ST_PTR) begin
                reg_addr_d = byte_in;
                state_d    = ST_ACK_P;
              end else begin
                reg_wdata_d = byte_in;
                reg_we_d    = 1'b1;
                state_d     = ST_ACK_W;
              end
            end
          end
        end
        // sda_oe_q doubles as the phase flag: first fall starts the ACK, second ends it.
        ST_ACK_A, ST_ACK_P, ST_ACK_W: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
              if (state_q == ST_ACK_A) begin
                if (shift_q[RW_BIT]) begin
                  state_d  = ST_READ;
                  reg_re_d = 1'b1;
                end else begin
                  state_d = ST_PTR;
                end
              end else begin
                if (state_q == ST_ACK_W) reg_addr_d = reg_addr_q + 8'd1;
                state_d = ST_WRITE;
              end
            end
          end
        end
        ST_READ: begin
          if (reg_re_q) begin
            shift_d  = reg_rdata;
            sda_oe_d = ~reg_rdata[7];
          end else if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) state_d = ST_MACK;
          end else if (scl_fall) begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
        end
        // bit_cnt sequences the ack slot: 0 release on fall, 1 sample on rise, 2 reload on fall.
        ST_MACK: begin
          if (bit_cnt_q == 3'd0 && scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd1;
          end else if (bit_cnt_q == 3'd1 && scl_rise) begin
            if (sda_level == ACK_LVL) begin
              reg_addr_d = reg_addr_q + 8'd1;
              bit_cnt_d  = 3'd2;
            end else begin
              state_d = ST_IGNORE;
            end
          end else if (bit_cnt_q == 3'd2 && scl_fall) begin
            state_d   = ST_READ;
            reg_re_d  = 1'b1;
            bit_cnt_d = 3'd0;
          end
        end
        ST_IDLE, ST_IGNORE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      busy_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      busy_q      <= busy_d;
      sda_oe_q    <= sda_oe_d;
    end
  end

  assign serial_data_line = sda_oe_q ? ACK_LVL : 1'bz;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench: a bit-banged I2C controller exercises write, read, miss, wrap, abort, glitch, reset.
module tb_i2c_target_regs;

  localparam int Q = 6;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       scl   = 1'b1;
  logic       m_sda = 1'b1;
  wire        sda_bus;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, reg_re, busy;
  logic [7:0] mem [256];

  pullup (sda_bus);
  assign sda_bus   = m_sda ? 1'bz : 1'b0;
  assign reg_rdata = mem[reg_addr];

  i2c_target_regs dut (
    .clock(clock), .reset(reset), .serial_clock_line(scl), .serial_data_line(sda_bus),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] we_log[$];
  int          re_cnt   = 0;
  int          low_cnt  = 0;

  always @(posedge clock) begin
    if (reg_we) we_log.push_back({reg_addr, reg_wdata});
    if (reg_re) re_cnt <= re_cnt + 1;
    if (m_sda && sda_bus === 1'b0) low_cnt <= low_cnt + 1;
  end

  function automatic logic [15:0] log_at(input int i);
    return (i < we_log.size()) ? we_log[i] : 16'hxxxx;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic i2c_start();
    if (!scl) begin
      wait_clks(Q); m_sda = 1'b1;
      wait_clks(Q); scl = 1'b1;
      wait_clks(2*Q);
    end
    m_sda = 1'b0;
    wait_clks(2*Q); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clks(Q); m_sda = 1'b0;
    wait_clks(Q); scl = 1'b1;
    wait_clks(2*Q); m_sda = 1'b1;
    wait_clks(2*Q);
  endtask

  task automatic send_bit(input logic b);
    wait_clks(Q); m_sda = b;
    wait_clks(Q); scl = 1'b1;
    wait_clks(2*Q); scl = 1'b0;
  endtask

  task automatic read_bit(output logic v);
    wait_clks(Q); m_sda = 1'b1;
    wait_clks(Q); scl = 1'b1;
    wait_clks(Q); v = sda_bus;
    wait_clks(Q); scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      read_bit(v);
      b[i] = v;
    end
    send_bit(mack);
  endtask

  task automatic test_reset();
    wait_clks(5);
    n_checks++; if (reg_addr !== 8'h00) $display("FAIL rst_addr got %h want 00", reg_addr); else n_pass++;
    n_checks++; if (reg_wdata !== 8'h00) $display("FAIL rst_wdata got %h want 00", reg_wdata); else n_pass++;
    n_checks++; if ({reg_we, reg_re, busy} !== 3'b000) $display("FAIL rst_strobes got %b want 000", {reg_we, reg_re, busy}); else n_pass++;
    n_checks++; if (sda_bus !== 1'b1) $display("FAIL rst_sda got %b want 1", sda_bus); else n_pass++;
    reset = 1'b1;
    wait_clks(5);
  endtask

  task automatic test_write();
    logic [3:0] acks;
    int base = we_log.size();
    i2c_start();
    write_byte(8'h34, acks[3]);
    write_byte(8'h05, acks[2]);
    write_byte(8'hA7, acks[1]);
    write_byte(8'h3C, acks[0]);
    n_checks++; if (acks !== 4'b0000) $display("FAIL wr_acks got %b want 0000", acks); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL wr_busy_hi got %b want 1", busy); else n_pass++;
    i2c_stop();
    n_checks++; if (busy !== 1'b0) $display("FAIL wr_busy_lo got %b want 0", busy); else n_pass++;
    n_checks++; if (we_log.size() - base !== 2) $display("FAIL wr_count got %0d want 2", we_log.size() - base); else n_pass++;
    n_checks++; if (log_at(base) !== 16'h05A7) $display("FAIL wr_first got %h want 05a7", log_at(base)); else n_pass++;
    n_checks++; if (log_at(base+1) !== 16'h063C) $display("FAIL wr_second got %h want 063c", log_at(base+1)); else n_pass++;
  endtask

  task automatic test_read();
    logic [2:0] acks;
    logic [7:0] b0, b1;
    int rbase = re_cnt;
    mem[8'h10] = 8'h5A;
    mem[8'h11] = 8'hC3;
    i2c_start();
    write_byte(8'h34, acks[2]);
    write_byte(8'h10, acks[1]);
    i2c_start();
    write_byte(8'h35, acks[0]);
    read_byte(1'b0, b0);
    read_byte(1'b1, b1);
    n_checks++; if (acks !== 3'b000) $display("FAIL rd_acks got %b want 000", acks); else n_pass++;
    n_checks++; if (b0 !== 8'h5A) $display("FAIL rd_byte0 got %h want 5a", b0); else n_pass++;
    n_checks++; if (b1 !== 8'hC3) $display("FAIL rd_byte1 got %h want c3", b1); else n_pass++;
    n_checks++; if (re_cnt - rbase !== 2) $display("FAIL rd_re_count got %0d want 2", re_cnt - rbase); else n_pass++;
    n_checks++; if (reg_addr !== 8'h11) $display("FAIL rd_ptr got %h want 11", reg_addr); else n_pass++;
    wait_clks(2*Q);
    n_checks++; if (sda_bus !== 1'b1) $display("FAIL rd_released got %b want 1", sda_bus); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL rd_busy_ignore got %b want 1", busy); else n_pass++;
    i2c_stop();
    n_checks++; if (busy !== 1'b0) $display("FAIL rd_busy_lo got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_miss();
    logic [1:0] acks;
    int wbase = we_log.size();
    int rbase = re_cnt;
    int lbase = low_cnt;
    i2c_start();
    write_byte(8'h36, acks[1]);
    write_byte(8'h01, acks[0]);
    n_checks++; if (busy !== 1'b0) $display("FAIL miss_busy got %b want 0", busy); else n_pass++;
    i2c_stop();
    n_checks++; if (acks !== 2'b11) $display("FAIL miss_acks got %b want 11", acks); else n_pass++;
    n_checks++; if (low_cnt - lbase !== 0) $display("FAIL miss_sda_driven got %0d want 0", low_cnt - lbase); else n_pass++;
    n_checks++; if ((we_log.size() - wbase) + (re_cnt - rbase) !== 0)
      $display("FAIL miss_strobes got %0d want 0", (we_log.size() - wbase) + (re_cnt - rbase)); else n_pass++;
  endtask

  task automatic test_wrap();
    logic ack;
    int base = we_log.size();
    i2c_start();
    write_byte(8'h34, ack);
    write_byte(8'hFF, ack);
    write_byte(8'h11, ack);
    write_byte(8'h22, ack);
    i2c_stop();
    n_checks++; if (log_at(base) !== 16'hFF11) $display("FAIL wrap_first got %h want ff11", log_at(base)); else n_pass++;
    n_checks++; if (log_at(base+1) !== 16'h0022) $display("FAIL wrap_second got %h want 0022", log_at(base+1)); else n_pass++;
  endtask

  task automatic test_abort();
    logic ack;
    int base = we_log.size();
    i2c_start();
    write_byte(8'h34, ack);
    write_byte(8'h20, ack);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    i2c_stop();
    n_checks++; if (we_log.size() - base !== 0) $display("FAIL abort_no_we got %0d want 0", we_log.size() - base); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (reg_addr !== 8'h20) $display("FAIL abort_ptr got %h want 20", reg_addr); else n_pass++;
    i2c_start();
    write_byte(8'h34, ack);
    write_byte(8'h30, ack);
    write_byte(8'h99, ack);
    i2c_stop();
    n_checks++; if (log_at(base) !== 16'h3099) $display("FAIL abort_next got %h want 3099", log_at(base)); else n_pass++;
  endtask

  task automatic test_glitch();
    logic ack;
    wait_clks(10);
    m_sda = 1'b0; wait_clks(1); m_sda = 1'b1;
    wait_clks(10);
    scl = 1'b0;
    write_byte(8'h34, ack);
    n_checks++; if (ack !== 1'b1) $display("FAIL glitch_start got %b want 1", ack); else n_pass++;
    i2c_stop();
    // A 1-clock high spike on SDA while SCL is high must not look like STOP then START.
    i2c_start();
    wait_clks(Q); m_sda = 1'b0;
    wait_clks(Q); scl = 1'b1;
    wait_clks(Q); m_sda = 1'b1; wait_clks(1); m_sda = 1'b0;
    wait_clks(Q-1); scl = 1'b0;
    for (int i = 6; i >= 0; i--) send_bit(logic'((8'h34 >> i) & 8'h01));
    read_bit(ack);
    n_checks++; if (ack !== 1'b0) $display("FAIL glitch_stop_ack got %b want 0", ack); else n_pass++;
    write_byte(8'h50, ack);
    i2c_stop();
    n_checks++; if (reg_addr !== 8'h50) $display("FAIL glitch_ptr got %h want 50", reg_addr); else n_pass++;
  endtask

  task automatic test_reset_midway();
    logic ack;
    int base;
    i2c_start();
    write_byte(8'h34, ack);
    write_byte(8'h40, ack);
    for (int i = 7; i >= 0; i--) send_bit(logic'((8'h55 >> i) & 8'h01));
    m_sda = 1'b1;
    wait_clks(Q+4);
    n_checks++; if (sda_bus !== 1'b0) $display("FAIL mid_ackw_drive got %b want 0", sda_bus); else n_pass++;
    n_checks++; if (reg_wdata !== 8'h55) $display("FAIL mid_wdata got %h want 55", reg_wdata); else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++; if (sda_bus !== 1'b1) $display("FAIL mid_rst_sda got %b want 1", sda_bus); else n_pass++;
    n_checks++; if ({reg_addr, reg_wdata} !== 16'h0000) $display("FAIL mid_rst_regs got %h want 0000", {reg_addr, reg_wdata}); else n_pass++;
    n_checks++; if ({reg_we, reg_re, busy} !== 3'b000) $display("FAIL mid_rst_ctl got %b want 000", {reg_we, reg_re, busy}); else n_pass++;
    wait_clks(4);
    reset = 1'b1;
    wait_clks(Q); scl = 1'b1;
    wait_clks(2*Q);
    base = we_log.size();
    i2c_start();
    write_byte(8'h34, ack);
    write_byte(8'h41, ack);
    write_byte(8'h77, ack);
    i2c_stop();
    n_checks++; if (log_at(base) !== 16'h4177) $display("FAIL mid_recover got %h want 4177", log_at(base)); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_miss();
    test_wrap();
    test_abort();
    test_glitch();
    test_reset_midway();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
